// File: rtl/token_uart_pkg.sv
// Shared types and constants for the token-to-ASCII UART line transmitter.
package token_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } line_state_t;

    localparam logic [7:0]  ASCII_T    = 8'h54;
    localparam logic [7:0]  ASCII_CR   = 8'h0D;
    localparam logic [7:0]  ASCII_LF   = 8'h0A;
    localparam int unsigned LINE_CHARS = 19;
    localparam int unsigned IDX_W      = 5;

    typedef logic [IDX_W-1:0] char_idx_t;

    // 0-9 -> '0'-'9', A-F -> 'A'-'F'
    function automatic logic [7:0] nib2hex(input logic [3:0] nib);
        if (nib < 4'd10)
            nib2hex = 8'h30 + {4'h0, nib};
        else
            nib2hex = 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART serialiser with a registered tx line; a new load is accepted in the
// final stop-bit cycle so back-to-back characters have no gap.
module uart_tx_8n1 #(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       load,
    output logic       tx,
    output logic       ready,
    output logic       done
);

    localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);

    logic [15:0] bit_cnt;
    logic [3:0]  bit_idx;
    logic [8:0]  shreg;
    logic        active;

    assign ready = ~active;
    assign done  = active && (bit_idx == 4'd9) && (bit_cnt == LAST_CLK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx      <= 1'b1;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            active  <= 1'b0;
        end else if (load && (ready || done)) begin
            // Start bit goes out immediately; stop bit rides in shreg[8].
            tx      <= 1'b0;
            shreg   <= {1'b1, data};
            bit_cnt <= '0;
            bit_idx <= '0;
            active  <= 1'b1;
        end else if (active) begin
            if (bit_cnt == LAST_CLK) begin
                bit_cnt <= '0;
                if (bit_idx == 4'd9) begin
                    bit_idx <= '0;
                    active  <= 1'b0;
                    tx      <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    tx      <= shreg[0];
                    shreg   <= {1'b1, shreg[8:1]};
                end
            end else begin
                bit_cnt <= bit_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/token_hex_uart_tx.sv
// Sends each 64-bit token as "T<16 hex digits>\r\n" over 8N1 UART, with a
// one-entry pending buffer and a sticky overrun flag.
module token_hex_uart_tx
    import token_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        token_valid,
    input  logic [63:0] token64,
    input  logic        flush,
    input  logic        clr_overrun,
    output logic        tx,
    output logic        busy,
    output logic        pending,
    output logic        overrun
);

    localparam char_idx_t IDX_LAST = char_idx_t'(LINE_CHARS - 1);
    localparam char_idx_t IDX_CR   = char_idx_t'(LINE_CHARS - 2);

    line_state_t state, state_next;
    char_idx_t   idx, idx_next, load_idx;
    logic [63:0] line_reg, pend_reg, nib_shift;
    logic        pend_valid, flush_q;
    logic        take_token, promote, overrun_set;
    logic        uart_load, uart_ready, uart_done;
    logic [7:0]  char_data;

    assign pending = pend_valid;

    always_comb begin
        nib_shift = line_reg >> {5'd16 - load_idx, 2'b00};
        case (load_idx)
            5'd0:     char_data = ASCII_T;
            IDX_CR:   char_data = ASCII_CR;
            IDX_LAST: char_data = ASCII_LF;
            default:  char_data = nib2hex(nib_shift[3:0]);
        endcase
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        load_idx   = idx;
        uart_load  = 1'b0;
        take_token = 1'b0;
        promote    = 1'b0;
        case (state)
            IDLE: begin
                if (pend_valid && !flush) begin
                    promote    = 1'b1;
                    idx_next   = '0;
                    state_next = SEND;
                end else if (token_valid && !flush) begin
                    take_token = 1'b1;
                    idx_next   = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (uart_ready) begin
                    if (flush || flush_q)
                        state_next = IDLE;
                    else
                        uart_load = 1'b1;
                end else if (uart_done) begin
                    if (flush || flush_q) begin
                        state_next = IDLE;
                    end else if (idx == IDX_LAST) begin
                        state_next = DONE;
                    end else begin
                        uart_load = 1'b1;
                        load_idx  = idx + 5'd1;
                        idx_next  = idx + 5'd1;
                    end
                end
            end
            DONE: begin
                // 'T' is loaded straight from DONE so only this cycle idles between lines.
                if (pend_valid && !flush) begin
                    promote    = 1'b1;
                    uart_load  = 1'b1;
                    load_idx   = '0;
                    idx_next   = '0;
                    state_next = SEND;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        overrun_set = token_valid && !flush && (state != IDLE) && pend_valid && !promote;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            line_reg   <= '0;
            pend_reg   <= '0;
            pend_valid <= 1'b0;
            flush_q    <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            busy  <= (state != IDLE) && (state_next != IDLE);

            if (take_token)
                line_reg <= token64;
            else if (promote)
                line_reg <= pend_reg;

            if (flush) begin
                pend_valid <= 1'b0;
            end else if (promote) begin
                pend_valid <= token_valid;
                if (token_valid)
                    pend_reg <= token64;
            end else if (token_valid && (state != IDLE) && !pend_valid) begin
                pend_reg   <= token64;
                pend_valid <= 1'b1;
            end

            if (overrun_set)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;

            if (state_next == IDLE)
                flush_q <= 1'b0;
            else if (flush && (state == SEND))
                flush_q <= 1'b1;
        end
    end

    uart_tx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (char_data),
        .load  (uart_load),
        .tx    (tx),
        .ready (uart_ready),
        .done  (uart_done)
    );

endmodule

// File: tb/tb_token_hex_uart_tx.sv
// Bench for token_hex_uart_tx: decodes the UART line and compares each byte
// and its start cycle against lines built from the token values.
module tb_token_hex_uart_tx;

    localparam int CPB      = 4;
    localparam int CHAR_CYC = 10 * CPB;
    localparam int LINE_CYC = 19 * CHAR_CYC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        token_valid = 1'b0;
    logic [63:0] token64 = '0;
    logic        flush = 1'b0;
    logic        clr_overrun = 1'b0;
    logic        tx, busy, pending, overrun;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int          cyc = 0;
    logic [7:0]  rx_q[$];
    int          rx_t[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    token_hex_uart_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .token_valid (token_valid),
        .token64     (token64),
        .flush       (flush),
        .clr_overrun (clr_overrun),
        .tx          (tx),
        .busy        (busy),
        .pending     (pending),
        .overrun     (overrun)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] line_char(input logic [63:0] tok, input int i);
        int d;
        if (i == 0)  return 8'h54;
        if (i == 17) return 8'h0D;
        if (i == 18) return 8'h0A;
        d = int'((tok >> (4 * (16 - i))) & 64'hF);
        return (d < 10) ? 8'(48 + d) : 8'(55 + d);
    endfunction

    // UART receiver: samples mid-bit, records byte and start-bit cycle.
    initial begin
        int         t0;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                t0 = cyc;
                repeat (CPB / 2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    b[k] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (rst_n) check("stop_bit", 64'(tx), 64'd1);
                rx_q.push_back(b);
                rx_t.push_back(t0);
            end
        end
    end

    task automatic pulse(input logic [63:0] tok, output int pc);
        @(posedge clk); #1;
        token_valid = 1'b1;
        token64     = tok;
        @(posedge clk); #1;
        token_valid = 1'b0;
        pc = cyc;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3000; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check(tag, 64'(busy), 64'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_t.delete();
    endtask

    task automatic verify_line(input string tag, input logic [63:0] tok, input int base,
                               input int st, input int nchars);
        logic [8:0] got;
        int         gt;
        for (int i = 0; i < nchars; i++) begin
            got = (base + i < rx_q.size()) ? {1'b0, rx_q[base + i]} : 9'h1FF;
            gt  = (base + i < rx_t.size()) ? rx_t[base + i] : -1;
            check($sformatf("%s_char[%0d]", tag, i), 64'(got), 64'(line_char(tok, i)));
            check($sformatf("%s_start[%0d]", tag, i), 64'(gt), 64'(st + CHAR_CYC * i));
        end
    endtask

    initial begin
        int          pc, pc2, bcnt;
        logic [63:0] ta, tb, tc;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 64'(tx), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // single line, busy width and start latency
        clear_rx();
        pulse(64'h0123_4567_89AB_CDEF, pc);
        bcnt = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            else if (bcnt > 0) break;
        end
        check("busy_cycles", 64'(bcnt), 64'(LINE_CYC + 1));
        repeat (4) @(negedge clk);
        check("single_len", 64'(rx_q.size()), 64'd19);
        verify_line("single", 64'h0123_4567_89AB_CDEF, 0, pc + 1, 19);

        // pending buffer, back-to-back lines with one idle cycle
        clear_rx();
        ta = {$urandom(), $urandom()};
        pulse(ta, pc);
        wait_until(pc + 100);
        pulse(64'hFFFF_0000_FFFF_0000, pc2);
        @(negedge clk);
        check("pend_set", 64'(pending), 64'd1);
        wait_idle("pend_idle");
        check("pend_overrun", 64'(overrun), 64'd0);
        check("pend_len", 64'(rx_q.size()), 64'd38);
        verify_line("pendA", ta, 0, pc + 1, 19);
        verify_line("pendB", 64'hFFFF_0000_FFFF_0000, 19, pc + 1 + LINE_CYC + 1, 19);

        // overrun: third token within the first line is lost
        clear_rx();
        ta = {$urandom(), $urandom()};
        tb = {$urandom(), $urandom()};
        tc = {$urandom(), $urandom()};
        pulse(ta, pc);
        wait_until(pc + 10 + int'($urandom_range(0, 200)));
        pulse(tb, pc2);
        wait_until(pc2 + 10 + int'($urandom_range(0, 200)));
        pulse(tc, pc2);
        @(negedge clk);
        check("ovr_set", 64'(overrun), 64'd1);
        wait_idle("ovr_idle");
        check("ovr_len", 64'(rx_q.size()), 64'd38);
        verify_line("ovrA", ta, 0, pc + 1, 19);
        verify_line("ovrB", tb, 19, pc + 1 + LINE_CYC + 1, 19);
        check("ovr_sticky", 64'(overrun), 64'd1);
        check("ovr_pending", 64'(pending), 64'd0);
        @(posedge clk); #1;
        clr_overrun = 1'b1;
        @(posedge clk); #1;
        clr_overrun = 1'b0;
        check("ovr_clr", 64'(overrun), 64'd0);

        // flush during character 5 with a token pending
        clear_rx();
        ta = {$urandom(), $urandom()};
        tb = {$urandom(), $urandom()};
        pulse(ta, pc);
        pulse(tb, pc2);
        wait_until(pc + 1 + 5 * CHAR_CYC + 10);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_pending", 64'(pending), 64'd0);
        repeat (300) @(negedge clk);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_tx", 64'(tx), 64'd1);
        check("flush_len", 64'(rx_q.size()), 64'd6);
        verify_line("flush", ta, 0, pc + 1, 6);

        // asynchronous reset mid-line
        ta = {$urandom(), $urandom()};
        pulse(ta, pc);
        pulse({$urandom(), $urandom()}, pc2);
        pulse({$urandom(), $urandom()}, pc2);
        wait_until(pc + 1 + CHAR_CYC + 15);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_tx", 64'(tx), 64'd1);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_pending", 64'(pending), 64'd0);
        check("mrst_overrun", 64'(overrun), 64'd0);
        repeat (60) @(posedge clk);
        clear_rx();
        #1;
        rst_n = 1'b1;
        ta = {$urandom(), $urandom()};
        pulse(ta, pc);
        wait_idle("mrst_idle");
        check("mrst_len", 64'(rx_q.size()), 64'd19);
        verify_line("mrst", ta, 0, pc + 1, 19);

        // hex map edges 9/A and F/0
        clear_rx();
        pulse(64'hA0A0_9F9F_0000_FFFF, pc);
        wait_idle("nib_idle");
        check("nib_len", 64'(rx_q.size()), 64'd19);
        verify_line("nib", 64'hA0A0_9F9F_0000_FFFF, 0, pc + 1, 19);

        // random tokens with random idle gaps
        for (int r = 0; r < 4; r++) begin
            clear_rx();
            ta = {$urandom(), $urandom()};
            repeat (int'($urandom_range(1, 20))) @(posedge clk);
            pulse(ta, pc);
            wait_idle($sformatf("rnd%0d_idle", r));
            check($sformatf("rnd%0d_len", r), 64'(rx_q.size()), 64'd19);
            verify_line($sformatf("rnd%0d", r), ta, 0, pc + 1, 19);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/token_hex_uart_tx.md
# token_hex_uart_tx

Downstream stage of the tokenisation path. Captures each 64-bit token on its single-cycle `token_valid` pulse and transmits it off-chip as an ASCII line over an 8N1 UART. The line is `'T'`, then 16 uppercase hex digits (MSB nibble first), then CR LF. A one-entry pending buffer absorbs a token that arrives while a line is still in flight.

## Interface
- `CLKS_PER_BIT`, default 87: clock cycles per UART bit (115200 baud at 10 MHz); legal range 2..65535.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `token_valid`  in  1: single-cycle pulse; `token64` is valid in the same cycle.
- `token64`  in  64: token value.
- `flush`  in  1: synchronous. Drops the pending token and ends the current line after the character in flight.
- `clr_overrun`  in  1: synchronous; clears `overrun`.
- `tx`  out  1: UART serial line; idles high.
- `busy`  out  1: high while a line is being transmitted.
- `pending`  out  1: pending buffer is occupied.
- `overrun`  out  1: sticky; a token was dropped.

## Operation
- Reset values: `tx`=1, `busy`=0, `pending`=0, `overrun`=0. FSM=IDLE. All counters and the shift register are 0.
- FSM states:
  - **IDLE**
    - `tx`=1.
    - `token_valid` → load the line register, go to SEND with char index 0.
  - **SEND**
    - Serialise character `idx` as: start bit (0), 8 data bits LSB-first, stop bit (1).
    - After the stop bit, `idx` increments.
    - After `idx`=18 completes, go to DONE.
  - **DONE** (one cycle)
    - If `pending`: move the pending token into the line register, clear `pending`, go to SEND with `idx`=0.
    - Otherwise go to IDLE.
- Character map:
  - `idx` 0 = 0x54 ('T').
  - `idx` 1..16 = hex of nibble `token[67-4*idx -: 4]`; 0–9 → 0x30–0x39, A–F → 0x41–0x46.
  - `idx` 17 = 0x0D.
  - `idx` 18 = 0x0A.
- `token_valid` while not IDLE:
  - If `pending`=0: store the token in the pending buffer and set `pending`.
  - If `pending`=1: drop the new token and set `overrun`. The stored pending token is kept.
- `token_valid` in the DONE cycle while `pending`=1: the pending token is promoted and the new token enters the empty buffer. No overrun.
- `flush`:
  - Clears `pending` immediately.
  - In SEND, the current character finishes through its stop bit, then the FSM goes to IDLE. The line is truncated and DONE is skipped.
  - In IDLE, no effect.
  - `flush` and `token_valid` in the same cycle: `flush` wins and the token is dropped without setting `overrun`.
- `clr_overrun` and an overrun event in the same cycle: set wins.
- Line register width: 64 bits. Nibbles are selected combinationally from the line register, not pre-converted.

## Timing
- `tx` is registered.
- Line start:
  - `token_valid` sampled at edge N → start bit appears on `tx` after edge N+1.
  - `busy` is high from edge N+1.
- Bit timing:
  - Each bit lasts exactly `CLKS_PER_BIT` cycles.
  - There are no inter-character gaps.
  - A full line is 190·`CLKS_PER_BIT` cycles.
- `busy`:
  - Stays high through DONE.
  - Drops one cycle after the final stop bit if nothing is pending.
- Back-to-back lines: when a line is pending, exactly one idle-high cycle separates the two lines (the DONE cycle).
- Bit counter wraps 0..`CLKS_PER_BIT`-1; character bit index wraps 0..9.
- Reset mid-line: `tx` goes high asynchronously and the line is abandoned. No partial character is completed.

## Structure
- Package `token_uart_pkg`:
  - State enum `{IDLE, SEND, DONE}`.
  - Constants `ASCII_T`=8'h54, `ASCII_CR`=8'h0D, `ASCII_LF`=8'h0A, `LINE_CHARS`=19.
  - Function `nib2hex(logic [3:0]) → logic [7:0]`.
- Sub-module `uart_tx_8n1`:
  - Inputs `data[7:0]` and a `load` strobe; outputs `tx`, `ready`, and a one-cycle `done` pulse.
  - Contains the baud counter and bit index.
- The parent owns the line FSM, character index, line register, pending buffer and flags.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- **Single line.** Pulse `token_valid` with `token64`=64'h0123_4567_89AB_CDEF → UART decoder receives 0x54, 0x30–0x39, 0x41–0x46, 0x0D, 0x0A. `busy` is high for 760+1 cycles. Start bit begins exactly 1 cycle after the pulse.
- **Pending buffer.** Second token 64'hFFFF_0000_FFFF_0000 pulsed at cycle 100 → `pending`=1. The second line `"TFFFF0000FFFF0000\r\n"` starts after one idle cycle. `overrun`=0.
- **Overrun.** Three tokens A, B, C pulsed within the first line → lines A and B are sent, C is lost, `overrun`=1. `clr_overrun` then returns it to 0.
- **Flush.** Assert `flush` during character `idx`=5 with a token pending → character 5 completes, `tx` stays high afterwards, `busy`=0, `pending`=0, and no further characters are sent.
- **Reset mid-line.** Assert `rst_n`=0 during a data bit → `tx`=1 and all outputs are at reset values within the same cycle. A new token after reset produces a full line.
- **Nibble boundaries.** `token64`=64'hA0A0_9F9F_0000_FFFF → characters "A0A09F9F0000FFFF", checking the 9/A and F/0 edges of the hex map.
